// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier: one SIZE-bit ripple adder reused for SIZE iterations.
// Latency: operands accepted at edge E, product valid after edge E+SIZE (fewer with early done).
// Backpressure: start_ready only in IDLE; DONE holds HM/LM until res_valid && res_ready.
//
// Ports:
//   i_clk, i_reset          rising-edge clock, synchronous active-high reset
//   i_start_valid/o_start_ready, i_a, i_b   operand handshake (unsigned a * b)
//   o_res_valid/i_res_ready, o_hm, o_lm     product handshake, {o_hm,o_lm} = a*b
//   o_busy                  high while a product is being computed or held
//
// Optional feature: define MULT_EARLY_DONE_EN to finish as soon as the remaining
// multiplier bits are all zero (RUN length = max(1, msb_index(b)+1)).

// SIZE-bit ripple-carry adder built from full-adder cells.
module yAdder #(
   parameter int SIZE = 4
) (
   input  logic [SIZE-1:0] i_a,
   input  logic [SIZE-1:0] i_b,
   input  logic            i_cin,
   output logic [SIZE-1:0] o_sum,
   output logic            o_cout
);

   logic [SIZE:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < SIZE; g++) begin : g_fa
      assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
   end

   assign o_cout = w_c[SIZE];

endmodule

module mult_seq_ctrl #(
   parameter int SIZE = 4
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start_valid,
   output logic            o_start_ready,
   input  logic [SIZE-1:0] i_a,
   input  logic [SIZE-1:0] i_b,
   output logic            o_res_valid,
   input  logic            i_res_ready,
   output logic [SIZE-1:0] o_hm,
   output logic [SIZE-1:0] o_lm,
   output logic            o_busy
);

   localparam int CW = $clog2(SIZE) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [SIZE-1:0] r_mcand;
   logic [SIZE:0]   r_acc;      // upper partial product plus carry
   logic [SIZE-1:0] r_mlr;      // lower product bits above, unconsumed multiplier below
   logic [CW-1:0]   r_cnt;

   logic [SIZE-1:0] w_addend;
   logic [SIZE-1:0] w_sum;
   logic            w_cout;
   logic [2*SIZE:0] w_step;     // {acc,mlr} after one normal iteration
   logic [2*SIZE:0] w_accmlr_nxt;
   logic            w_last;
   logic            w_finish;
   logic            w_accept;
   logic            w_release;

   // The carry-out is always shifted down into acc[SIZE-1], so the top bit is
   // structurally zero between iterations; it is kept only to mirror the datapath.
   logic            w_unused_acc_msb;
   assign w_unused_acc_msb = r_acc[SIZE];

   // ------------------------------------------------------------------
   // Datapath: single shared adder
   // ------------------------------------------------------------------
   assign w_addend = r_mlr[0] ? r_mcand : '0;

   yAdder #(.SIZE(SIZE)) u_add (
      .i_a    (r_acc[SIZE-1:0]),
      .i_b    (w_addend),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // {1'b0, cout, sum, mlr} >> 1, with the consumed multiplier bit dropped.
   assign w_step = {1'b0, w_cout, w_sum, r_mlr[SIZE-1:1]};
   assign w_last = (r_cnt == CW'(SIZE - 1));

`ifdef MULT_EARLY_DONE_EN
   logic          w_rem_zero;
   logic [CW-1:0] w_shamt;

   // Multiplier bits still unconsumed after this iteration sit in
   // r_mlr[SIZE-1-cnt:1]; if all are zero, the remaining iterations would only add 0.
   always_comb begin
      w_rem_zero = 1'b1;
      for (int i = 1; i < SIZE; i++) begin
         if (((i + int'(r_cnt)) <= (SIZE - 1)) && r_mlr[i]) begin
            w_rem_zero = 1'b0;
         end
      end
   end

   // Skipped iterations are pure right shifts: SIZE-1-cnt beyond the current one.
   assign w_shamt      = CW'(SIZE - 1) - r_cnt;
   assign w_accmlr_nxt = w_rem_zero ? (w_step >> w_shamt) : w_step;
   assign w_finish     = w_last | w_rem_zero;
`else
   assign w_accmlr_nxt = w_step;
   assign w_finish     = w_last;
`endif

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      o_start_ready = 1'b0;
      o_res_valid   = 1'b0;
      o_busy        = 1'b0;
      w_accept      = 1'b0;
      w_release     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_start_ready = 1'b1;
            if (i_start_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            o_busy = 1'b1;
            if (w_finish) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            o_busy      = 1'b1;
            o_res_valid = 1'b1;
            if (i_res_ready) begin
               w_release   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Operand / partial-product registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_mcand <= '0;
         r_acc   <= '0;
         r_mlr   <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_accept) begin
            r_mcand <= i_a;
            r_acc   <= '0;
            r_mlr   <= i_b;
            r_cnt   <= '0;
         end else if (r_state == ST_RUN) begin
            {r_acc, r_mlr} <= w_accmlr_nxt;
            r_cnt          <= r_cnt + CW'(1);
         end
      end
   end

   // In DONE nothing updates acc/mlr, so the product is held through any stall.
   // After release the registers keep the last product until the next accept.
   logic w_unused_release;
   assign w_unused_release = w_release;

   assign o_hm = r_acc[SIZE-1:0];
   assign o_lm = r_mlr;

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequential shift-and-add multiplier controller. It owns one SIZE-bit ripple adder (`yAdder`) and sequences it over multiple cycles to produce the same 2·SIZE-bit product that `mult4` produces combinationally: high half on HM, low half on LM. Operands enter through a valid/ready start handshake, and results leave through a valid/ready result handshake. The block is the area-reduced multiply path of the datapath: one adder instead of SIZE-1.

## Interface
- SIZE, 4, operand width; the product is 2·SIZE bits, split into HM/LM
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start_valid  input  1  operands a/b are valid
- start_ready  output  1  controller can accept operands (IDLE only)
- a  input  SIZE  multiplicand, unsigned
- b  input  SIZE  multiplier, unsigned
- res_valid  output  1  HM/LM hold a finished product
- res_ready  input  1  consumer accepts the product
- HM  output  SIZE  product bits [2·SIZE-1:SIZE]
- LM  output  SIZE  product bits [SIZE-1:0]
- busy  output  1  high in RUN or DONE

## Operation
- Registers:
  - mcand[SIZE-1:0]
  - acc[SIZE:0] (upper partial product plus carry)
  - mlr[SIZE-1:0] (lower product / unconsumed multiplier)
  - cnt[log2(SIZE):0]
  - state
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: mcand<=a, acc<=0, mlr<=b, cnt<=0, go to RUN.
- RUN, one iteration per cycle:
  - sum = acc[SIZE-1:0] + (mlr[0] ? mcand : 0), computed through the single `yAdder`, cin=0.
  - {acc,mlr} <= {1'b0, cout, sum, mlr} >> 1.
  - cnt <= cnt+1.
  - When cnt==SIZE-1, go to DONE.
- DONE:
  - res_valid=1; {HM,LM} = {acc[SIZE-1:0], mlr}.
  - HM/LM are held stable until res_valid&&res_ready; then go to IDLE.
- start_valid outside IDLE is ignored, and a/b are not sampled.
- Arithmetic is unsigned. The product always fits in 2·SIZE bits, and acc[SIZE] is 0 in DONE.

## Timing
- Reset values: state=IDLE, start_ready=1, res_valid=0, busy=0, HM=0, LM=0, all internal registers 0.
- Latency: accept edge E → res_valid high after edge E+SIZE (SIZE RUN cycles). Early-done configuration changes this (see Configuration).
- start_ready is combinational from state. res_valid and HM/LM are driven from registers.
- Throughput: one product per SIZE+2 cycles at best:
  - the DONE→IDLE handshake costs a cycle;
  - the IDLE accept costs a cycle.
- The result and start handshakes can never coincide, because start_ready=0 in DONE.
- Reset asserted in any state wins over every other event:
  - the next cycle is IDLE with reset values;
  - an in-flight product is discarded without res_valid.
- res_ready held low in DONE stalls indefinitely with outputs unchanged.
- res_ready high in IDLE or RUN has no effect.

## Configuration
- Macro: MULT_EARLY_DONE_EN.
- Defined:
  - In RUN, if the multiplier bits still unconsumed after the current iteration are all zero, the remaining shifts are applied in the same cycle and the state goes to DONE.
  - RUN length = max(1, msb_index(b)+1). b=0 gives 1 cycle; b=1 gives 1 cycle.
  - The product value is identical to the non-early path.
- Undefined: RUN always lasts exactly SIZE cycles, regardless of b.

## Test plan
- Basic, SIZE=4:
  - Stimulus: a=13, b=11, accept at edge E, res_ready=1.
  - Response: HM=4'h8, LM=4'hF (143) with res_valid after edge E+4; start_ready high again the cycle after the result handshake.
- Max operands:
  - Stimulus: a=15, b=15.
  - Response: HM=4'hE, LM=4'h1 (225); acc[SIZE] observed 0 in DONE.
- Early done:
  - Stimulus: a=9, b=0, then a=9, b=2.
  - Response with MULT_EARLY_DONE_EN: products 0 and 18 (HM=1, LM=2) after 1 and 2 RUN cycles.
  - Response without the macro: 4 RUN cycles each.
- Backpressure and ignored start:
  - Stimulus: a=7, b=6; res_ready low for 3 cycles in DONE; start_valid pulsed high during RUN and DONE.
  - Response: HM=2, LM=A (42) held constant across the stall; start_valid is not accepted; busy=1 throughout.
- Reset mid-operation:
  - Stimulus: accept a=5, b=5; assert reset at RUN cycle 2 for one cycle; then run a=3, b=4.
  - Response: no res_valid for the first operation; outputs are 0 after reset; the second product is 12 (HM=0, LM=C) at the nominal latency.
- Random:
  - Stimulus: 200 random a/b pairs with random res_ready stalls.
  - Response: every {HM,LM} equals a*b, matching `mult4` on the same operands.
